// File: rtl/morse_pkg.sv
// Shared types and timing thresholds for the Morse receiver.
// All thresholds are in Morse time units.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_DROP  = 2'd3
  } state_e;

  localparam logic [2:0] DASH_UNITS     = 3'd2;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd2;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd5;
  localparam logic [2:0] DROP_GAP_UNITS = 3'd3;
  localparam logic [2:0] MAX_MARK_UNITS = 3'd7;
  localparam logic [2:0] MAX_ELEMS      = 3'd5;

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer.
// The level flips only after the synchronized input disagrees for DEBOUNCE_CYCLES in a row.
module morse_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16000
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw_in,
  output logic level
);
  import morse_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any cycle of agreement leaves cnt_d at zero, restarting the stability count.
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/morse_rx.sv
// Morse decoder: debounced key -> unit timing -> element buffer -> character/word events.
// Up to five elements are buffered; longer characters and stuck marks are dropped with ERR.
module morse_rx #(
  parameter int unsigned UNIT_CYCLES     = 2097152,
  parameter int unsigned DEBOUNCE_CYCLES = 16000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       MORSE_IN,
  output logic       LED,
  output logic       SYM_VALID,
  output logic [2:0] SYM_LEN,
  output logic [4:0] SYM_BITS,
  output logic       WORD_VALID,
  output logic       ERR
);
  import morse_pkg::*;

  localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  logic          level;
  logic          prev_q, prev_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    units_q, units_d, units_inc;
  state_e        state_q, state_d;
  logic [2:0]    count_q, count_d;
  logic [4:0]    bits_q, bits_d;
  logic          sym_valid_q, sym_valid_d;
  logic [2:0]    sym_len_q, sym_len_d;
  logic [4:0]    sym_bits_q, sym_bits_d;
  logic          word_valid_q, word_valid_d;
  logic          err_q, err_d;
  logic          rise, fall, edge_any, tick_raw, tick, dash;

  morse_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .CLK    (CLK),
    .RST    (RST),
    .raw_in (MORSE_IN),
    .level  (level)
  );

  always_comb begin
    rise      = level & ~prev_q;
    fall      = ~level & prev_q;
    edge_any  = rise | fall;
    tick_raw  = (presc_q == PW'(UNIT_CYCLES - 1));
    // An edge restarts timing, so a tick landing on the same cycle is discarded.
    tick      = tick_raw & ~edge_any;
    units_inc = (units_q == MAX_MARK_UNITS) ? units_q : units_q + 3'd1;
    dash      = (units_q >= DASH_UNITS);

    prev_d       = level;
    presc_d      = (edge_any || tick_raw) ? '0 : presc_q + PW'(1);
    units_d      = edge_any ? 3'd0 : (tick ? units_inc : units_q);
    state_d      = state_q;
    count_d      = count_q;
    bits_d       = bits_q;
    sym_valid_d  = 1'b0;
    sym_len_d    = sym_len_q;
    sym_bits_d   = sym_bits_q;
    word_valid_d = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MARK;
          count_d = 3'd0;
          bits_d  = 5'd0;
        end
      end
      ST_MARK: begin
        if (fall) begin
          if (count_q == MAX_ELEMS) begin
            err_d   = 1'b1;
            count_d = 3'd0;
            bits_d  = 5'd0;
            state_d = ST_DROP;
          end else begin
            bits_d  = bits_q | (5'(dash) << count_q);
            count_d = count_q + 3'd1;
            state_d = ST_SPACE;
          end
        end else if (tick && units_q == MAX_MARK_UNITS) begin
          err_d   = 1'b1;
          count_d = 3'd0;
          bits_d  = 5'd0;
          state_d = ST_DROP;
        end
      end
      ST_SPACE: begin
        if (rise) begin
          state_d = ST_MARK;
          if (units_q >= CHAR_GAP_UNITS) begin
            count_d = 3'd0;
            bits_d  = 5'd0;
          end
        end else if (tick) begin
          if (units_inc == CHAR_GAP_UNITS && count_q != 3'd0) begin
            sym_valid_d = 1'b1;
            sym_len_d   = count_q;
            sym_bits_d  = bits_q;
            count_d     = 3'd0;
            bits_d      = 5'd0;
          end else if (units_inc == WORD_GAP_UNITS) begin
            word_valid_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (tick && !level && units_inc == DROP_GAP_UNITS) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q       <= 1'b0;
      presc_q      <= '0;
      units_q      <= 3'd0;
      state_q      <= ST_IDLE;
      count_q      <= 3'd0;
      bits_q       <= 5'd0;
      sym_valid_q  <= 1'b0;
      sym_len_q    <= 3'd0;
      sym_bits_q   <= 5'd0;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      presc_q      <= presc_d;
      units_q      <= units_d;
      state_q      <= state_d;
      count_q      <= count_d;
      bits_q       <= bits_d;
      sym_valid_q  <= sym_valid_d;
      sym_len_q    <= sym_len_d;
      sym_bits_q   <= sym_bits_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
    end
  end

  assign LED        = level;
  assign SYM_VALID  = sym_valid_q;
  assign SYM_LEN    = sym_len_q;
  assign SYM_BITS   = sym_bits_q;
  assign WORD_VALID = word_valid_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_morse_rx.sv
// Directed bench for morse_rx: stimulus pushes expected events, a monitor pops and compares them.
// Durations are in clock cycles with UNIT_CYCLES=16, DEBOUNCE_CYCLES=4.
module tb_morse_rx;
  localparam int U  = 16;
  localparam int DB = 4;
  localparam int K_SYM  = 0;
  localparam int K_WORD = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int       kind;
    logic [2:0] len;
    logic [4:0] bits;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       MORSE_IN;
  logic       LED;
  logic       SYM_VALID;
  logic [2:0] SYM_LEN;
  logic [4:0] SYM_BITS;
  logic       WORD_VALID;
  logic       ERR;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  always #5 CLK = ~CLK;

  morse_rx #(.UNIT_CYCLES(U), .DEBOUNCE_CYCLES(DB)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .MORSE_IN   (MORSE_IN),
    .LED        (LED),
    .SYM_VALID  (SYM_VALID),
    .SYM_LEN    (SYM_LEN),
    .SYM_BITS   (SYM_BITS),
    .WORD_VALID (WORD_VALID),
    .ERR        (ERR)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [2:0] len, input logic [4:0] bits);
    ev_t e;
    e.kind = kind;
    e.len  = len;
    e.bits = bits;
    exp_q.push_back(e);
  endtask

  // Holds MORSE_IN at v for n cycles; entered and left just after a rising edge.
  task automatic drive(input logic v, input int n);
    MORSE_IN = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    @(negedge CLK);
    chk({tag, "_led"}, int'(LED), 0);
    chk({tag, "_sym_valid"}, int'(SYM_VALID), 0);
    chk({tag, "_sym_len"}, int'(SYM_LEN), 0);
    chk({tag, "_sym_bits"}, int'(SYM_BITS), 0);
    chk({tag, "_word_valid"}, int'(WORD_VALID), 0);
    chk({tag, "_err"}, int'(ERR), 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic monitor();
    ev_t e;
    int  kind;
    forever begin
      @(negedge CLK);
      if (!RST && (SYM_VALID || WORD_VALID || ERR)) begin
        chk("pulse_onehot", $countones({SYM_VALID, WORD_VALID, ERR}), 1);
        kind = SYM_VALID ? K_SYM : (WORD_VALID ? K_WORD : K_ERR);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual=kind%0d len=%0d bits=%b required=no_event",
                   kind, SYM_LEN, SYM_BITS);
        end else begin
          e = exp_q.pop_front();
          $display("event t=%0t kind=%0d len=%0d bits=%b", $time, kind, SYM_LEN, SYM_BITS);
          chk("event_kind", kind, e.kind);
          if (e.kind == K_SYM) begin
            chk("sym_len", int'(SYM_LEN), int'(e.len));
            chk("sym_bits", int'(SYM_BITS), int'(e.bits));
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    int led_seen;
    RST      = 1'b1;
    MORSE_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_zero("reset_hold");
    RST = 1'b0;
    chk_zero("reset_after");

    // SOS with exact unit lengths: every edge lands on a tick, which must be ignored.
    push(K_SYM, 3'd3, 5'b00000);
    push(K_SYM, 3'd3, 5'b00111);
    push(K_SYM, 3'd3, 5'b00000);
    push(K_WORD, 3'd0, 5'd0);
    for (int c = 0; c < 3; c++) begin
      for (int e = 0; e < 3; e++) begin
        drive(1'b1, (c == 1) ? 3 * U : U);
        if (e < 2) drive(1'b0, U);
      end
      drive(1'b0, (c < 2) ? 3 * U : 7 * U);
    end

    // Short glitch must not reach the debounced level.
    led_seen = 0;
    drive(1'b1, 2);
    MORSE_IN = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      if (LED) led_seen = 1;
    end
    @(posedge CLK);
    #1;
    chk("glitch_led", led_seen, 0);

    // A 1-unit mark's fall coincides with a tick; a 1.5-unit gap must keep the character.
    push(K_SYM, 3'd2, 5'b00010);
    push(K_WORD, 3'd0, 5'd0);
    drive(1'b1, U);
    drive(1'b0, U + U / 2);
    drive(1'b1, 2 * U + U / 2);
    drive(1'b0, 7 * U);

    // Six elements overflow the buffer; an ignored mark in DROP, then recovery to IDLE.
    push(K_ERR, 3'd0, 5'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, U);
      if (i < 5) drive(1'b0, U);
    end
    drive(1'b0, 2 * U + U / 2);
    drive(1'b1, U + U / 2);
    drive(1'b0, 12 * U + U / 2);
    push(K_SYM, 3'd1, 5'b00000);
    push(K_WORD, 3'd0, 5'd0);
    drive(1'b1, U);
    drive(1'b0, 7 * U);

    // Stuck mark: ERR when units saturate, then a 3.5-unit space returns to IDLE.
    push(K_ERR, 3'd0, 5'd0);
    drive(1'b1, 5 * U);
    chk("led_mark", int'(LED), 1);
    drive(1'b1, 5 * U);
    drive(1'b0, 3 * U + U / 2);
    push(K_SYM, 3'd1, 5'b00000);
    push(K_WORD, 3'd0, 5'd0);
    drive(1'b1, U);
    drive(1'b0, 7 * U);

    // Reset after two elements discards them silently; SYM_LEN/BITS clear too.
    drive(1'b1, U);
    drive(1'b0, U);
    drive(1'b1, U);
    drive(1'b0, 8);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk_zero("midchar_rst_hold");
    RST = 1'b0;
    chk_zero("midchar_rst_after");
    push(K_SYM, 3'd1, 5'b00000);
    push(K_WORD, 3'd0, 5'd0);
    drive(1'b1, U);
    drive(1'b0, 3 * U);
    drive(1'b0, 5 * U);

    repeat (20) @(posedge CLK);
    #1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    chk("pending_events", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_rx.md
MORSE_RX -- requirements
Module: morse_rx

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 2097152: clocks per Morse time unit (2^21 at 16 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16000: clocks the synchronized input must be stable before the debounced level changes.
REQ-003 SHALL have port CLK  input  1  16 MHz clock; the only clock.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port MORSE_IN  input  1  asynchronous keyed signal, 1 = mark.
REQ-006 SHALL have port LED  output  1  debounced MORSE_IN level.
REQ-007 SHALL have port SYM_VALID  output  1  one-cycle pulse: character complete.
REQ-008 SHALL have port SYM_LEN  output  3  element count 1..5 of the last character.
REQ-009 SHALL have port SYM_BITS  output  5  elements of the last character; 1 = dash, 0 = dot; first element in bit 0; unused bits 0.
REQ-010 SHALL have port WORD_VALID  output  1  one-cycle pulse: word gap detected.
REQ-011 SHALL have port ERR  output  1  one-cycle pulse: character dropped.

Function
REQ-012 SHALL pass MORSE_IN through a 2-flop synchronizer.
REQ-013 SHALL toggle the debounced level when the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; the stability count restarts on any agreement.
REQ-014 SHALL derive a unit tick from a prescaler that counts 0..UNIT_CYCLES-1 and clears on every debounced edge.
REQ-015 SHALL keep a unit counter, 3 bits: cleared on every debounced edge, incremented on each unit tick, saturating at 7.
REQ-016 SHALL give a debounced edge priority over a unit tick in the same cycle; that tick is discarded.
REQ-017 SHALL implement states IDLE, MARK, SPACE and DROP.
REQ-018 IDLE: on rising edge -> MARK; the element buffer is empty.
REQ-019 MARK, falling edge with units 0..1: SHALL append a dot; with units 2..7: SHALL append a dash; then -> SPACE.
REQ-020 MARK, appending a 6th element: SHALL pulse ERR, clear the buffer and go -> DROP.
REQ-021 MARK, unit tick while units = 7 (stuck mark): SHALL pulse ERR, clear the buffer and go -> DROP.
REQ-022 SPACE, rising edge with units < 2: -> MARK, buffer kept.
REQ-023 SPACE, unit tick making units = 2 with buffer non-empty: SHALL pulse SYM_VALID, load SYM_LEN/SYM_BITS and clear the buffer in the same cycle; state stays SPACE.
REQ-024 SPACE, rising edge with units >= 2: -> MARK with an empty buffer.
REQ-025 SPACE, unit tick making units = 5: SHALL pulse WORD_VALID and go -> IDLE.
REQ-026 DROP: SHALL ignore marks; SHALL go -> IDLE after a space reaches 3 units; a rising edge restarts the wait.
REQ-027 SHALL hold SYM_LEN and SYM_BITS stable between SYM_VALID pulses.
REQ-028 SHALL never assert SYM_VALID, WORD_VALID and ERR in the same cycle.
REQ-029 LED SHALL equal the debounced level every cycle.

Reset
REQ-030 RST SHALL clear the synchronizer, debounced level, prescaler, unit counter and buffer, and set state = IDLE.
REQ-031 While RST is high and on the first cycle after it, LED, SYM_VALID, SYM_LEN, SYM_BITS, WORD_VALID and ERR SHALL all be 0.
REQ-032 RST asserted mid-character SHALL discard the partial character with no ERR pulse.

Structure
REQ-033 SHALL put the state enum and constants DASH_UNITS=2, CHAR_GAP_UNITS=2, WORD_GAP_UNITS=5, DROP_GAP_UNITS=3, MAX_MARK_UNITS=7 and MAX_ELEMS=5 in shared package morse_pkg.
REQ-034 SHALL place the synchronizer and debouncer in sub-module morse_debounce (CLK, RST, raw in, debounced level out).

Verification (UNIT_CYCLES=16, DEBOUNCE_CYCLES=4)
REQ-035 SOS pattern (marks 1,1,1 / 3,3,3 / 1,1,1 units, 1-unit intra gaps, 3-unit char gaps, trailing 7-unit gap) -> three SYM_VALID pulses with LEN/BITS = 3/00000, 3/00111, 3/00000, then one WORD_VALID.
REQ-036 A 2-cycle glitch on MORSE_IN -> LED and all outputs unchanged.
REQ-037 Six 1-unit marks separated by 1-unit gaps -> ERR on the 6th falling edge, no SYM_VALID, WORD_VALID only if a later space reaches 5 units after leaving DROP.
REQ-038 Mark held for 10 units -> ERR when units saturate at 7; after release plus a 3-unit space, state = IDLE.
REQ-039 RST pulsed after 2 elements -> outputs all 0; a following single 1-unit mark then 3-unit space -> SYM_VALID with LEN=1, BITS=00000.
REQ-040 Debounced falling edge coinciding with a unit tick -> tick ignored, units = 0; a mark of exactly 2 units -> dash.
